// File: rtl/button_step_ctrl.sv
// Debounced up/down pushbutton controller producing step strobes with hold-to-repeat.
// Optional fast stepping (inc=1 after FAST_REPS repeats) is enabled by defining BUTTON_STEP_FAST_EN.
module button_step_ctrl #(
    parameter int TICK_DIV   = 50000,
    parameter int DEB_TICKS  = 10,
    parameter int HOLD_TICKS = 500,
    parameter int REP_TICKS  = 100,
    parameter int FAST_REPS  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    output logic EN,
    output logic cnt,
    output logic inc
);

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX = (DEB_TICKS > HOLD_TICKS)
                        ? ((DEB_TICKS > REP_TICKS) ? DEB_TICKS : REP_TICKS)
                        : ((HOLD_TICKS > REP_TICKS) ? HOLD_TICKS : REP_TICKS);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL, LOCKOUT
    } state_t;

    logic          up_s1, up_s2, dn_s1, dn_s2;
    logic [PW-1:0] presc;
    logic          tick;
    state_t        state;
    logic          dir;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] step_lim;
    logic          act, both, none;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_s1 <= 1'b0;
            up_s2 <= 1'b0;
            dn_s1 <= 1'b0;
            dn_s2 <= 1'b0;
        end else begin
            up_s1 <= btn_up;
            up_s2 <= up_s1;
            dn_s1 <= btn_dn;
            dn_s2 <= dn_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            presc <= '0;
        else if (presc == PW'(TICK_DIV - 1))
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    assign tick = (presc == PW'(TICK_DIV - 1));
    assign act  = dir ? dn_s2 : up_s2;
    assign both = up_s2 & dn_s2;
    assign none = ~up_s2 & ~dn_s2;

    // HELD waits the long hold interval, REPEAT the shorter repeat interval.
    always_comb begin
        step_lim = TW'(REP_TICKS - 1);
        if (state == HELD)
            step_lim = TW'(HOLD_TICKS - 1);
    end

`ifdef BUTTON_STEP_FAST_EN
    localparam int RW = (FAST_REPS > 0) ? $clog2(FAST_REPS + 1) : 1;
    logic [RW-1:0] rep_cnt;
`else
    assign inc = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dir   <= 1'b0;
            tcnt  <= '0;
            EN    <= 1'b0;
            cnt   <= 1'b0;
`ifdef BUTTON_STEP_FAST_EN
            inc     <= 1'b0;
            rep_cnt <= '0;
`endif
        end else begin
            EN <= 1'b0;
`ifdef BUTTON_STEP_FAST_EN
            if (state == IDLE)
                rep_cnt <= '0;
`endif
            if (tick) begin
                case (state)
                    IDLE: begin
                        // The sample that starts the debounce counts as the first stable tick.
                        if (up_s2 ^ dn_s2) begin
                            dir   <= dn_s2;
                            tcnt  <= TW'(1);
                            state <= DEB_PRESS;
                        end
                    end
                    DEB_PRESS: begin
                        if (both) begin
                            tcnt  <= '0;
                            state <= LOCKOUT;
                        end else if (!act) begin
                            state <= IDLE;
                        end else if (tcnt >= TW'(DEB_TICKS - 1)) begin
                            EN    <= 1'b1;
                            cnt   <= dir;
`ifdef BUTTON_STEP_FAST_EN
                            inc   <= 1'b0;
`endif
                            tcnt  <= '0;
                            state <= HELD;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    HELD, REPEAT: begin
                        if (both) begin
                            tcnt  <= '0;
                            state <= LOCKOUT;
                        end else if (!act) begin
                            tcnt  <= TW'(1);
                            state <= DEB_REL;
                        end else if (tcnt >= step_lim) begin
                            EN    <= 1'b1;
                            cnt   <= dir;
`ifdef BUTTON_STEP_FAST_EN
                            inc   <= (rep_cnt >= RW'(FAST_REPS));
                            if (rep_cnt < RW'(FAST_REPS))
                                rep_cnt <= rep_cnt + 1'b1;
`endif
                            tcnt  <= '0;
                            state <= REPEAT;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    DEB_REL: begin
                        if (both) begin
                            tcnt  <= '0;
                            state <= LOCKOUT;
                        end else if (act) begin
                            tcnt <= '0;
                        end else if (tcnt >= TW'(DEB_TICKS - 1)) begin
                            state <= IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    LOCKOUT: begin
                        if (!none) begin
                            tcnt <= '0;
                        end else if (tcnt >= TW'(DEB_TICKS - 1)) begin
                            state <= IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/button_step_ctrl.md
BUTTON_STEP_CTRL -- requirements
Module: button_step_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per internal sample tick (1 kHz at 50 MHz).
REQ-002 Parameter DEB_TICKS, default 10, consecutive stable ticks required to accept a press or a release.
REQ-003 Parameter HOLD_TICKS, default 500, ticks from the first pulse until the first auto-repeat pulse.
REQ-004 Parameter REP_TICKS, default 100, ticks between auto-repeat pulses.
REQ-005 Parameter FAST_REPS, default 8, auto-repeat pulses before fast stepping begins.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 Port clk, input, 1, sole clock, rising edge.
REQ-008 Port rst, input, 1, asynchronous active-low reset.
REQ-009 Port btn_up, input, 1, raw asynchronous up pushbutton, active-high.
REQ-010 Port btn_dn, input, 1, raw asynchronous down pushbutton, active-high.
REQ-011 Port EN, output, 1, one-cycle step strobe to the downstream modulo-N counter.
REQ-012 Port cnt, output, 1, direction: 0 = count up, 1 = count down.
REQ-013 Port inc, output, 1, step size: 0 = step 1, 1 = step 2.

Function
REQ-014 btn_up and btn_dn SHALL each pass through a 2-flop synchronizer before any use (2 clk latency).
REQ-015 A free-running prescaler SHALL count 0..TICK_DIV-1 and assert an internal tick for one clk when the count is TICK_DIV-1.
REQ-016 The FSM SHALL implement states IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL and LOCKOUT, and SHALL evaluate all button conditions only on tick cycles.
REQ-017 IDLE -> DEB_PRESS when exactly one synchronized button is high; the FSM SHALL latch that button as the active direction.
REQ-018 DEB_PRESS SHALL return to IDLE if the active button drops before DEB_TICKS consecutive high ticks.
REQ-019 On reaching DEB_TICKS, DEB_PRESS -> HELD with a single EN pulse, cnt = active direction, and inc = 0.
REQ-020 In HELD, after HOLD_TICKS ticks with the active button still high, the FSM SHALL pulse EN and move to REPEAT.
REQ-021 In REPEAT, the FSM SHALL pulse EN every REP_TICKS ticks while the active button stays high.
REQ-022 A saturating repeat counter SHALL count auto-repeat pulses; inc SHALL be 1 on repeat pulses after the first FAST_REPS repeat pulses (fast-step feature).
REQ-023 Active button low in HELD or REPEAT -> DEB_REL; DEB_REL returns to IDLE after DEB_TICKS consecutive low ticks.
REQ-024 A high sample during DEB_REL SHALL restart its count, and no EN pulse SHALL be emitted in DEB_REL.
REQ-025 Both buttons high on any tick in DEB_PRESS, HELD, REPEAT or DEB_REL -> LOCKOUT; LOCKOUT SHALL emit no pulses and exit to IDLE after DEB_TICKS consecutive ticks with both buttons low.
REQ-026 Both buttons high in IDLE SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-027 EN SHALL be high for exactly one clk, in the cycle after the qualifying tick.
REQ-028 cnt and inc SHALL change only in the cycle EN asserts, and SHALL hold their values between pulses.
REQ-029 The repeat counter SHALL clear on entry to IDLE.

Reset
REQ-030 While rst is low, the block SHALL force EN = 0, cnt = 0, inc = 0, FSM = IDLE, and clear the prescaler, synchronizers, tick counters and repeat counter, independent of clk.
REQ-031 Reset asserted mid-hold SHALL cancel all pending pulses; after release the block SHALL require a fresh debounced press before any pulse.

Configuration
REQ-032 Macro BUTTON_STEP_FAST_EN defined: fast stepping SHALL operate per REQ-022.
REQ-033 Macro BUTTON_STEP_FAST_EN undefined: inc SHALL be tied to 0, the repeat counter SHALL be omitted, and all other behaviour SHALL be unchanged.

Verification (TICK_DIV=4, DEB_TICKS=3, HOLD_TICKS=10, REP_TICKS=5, FAST_REPS=2)
REQ-034 btn_up held 100 ticks -> first EN with cnt=0, inc=0; repeats at +10, +15, +20, +25 ticks; inc=1 from the 3rd repeat (macro defined), inc=0 throughout (macro undefined).
REQ-035 btn_dn bouncing high/low every tick for 6 ticks, then stable low -> zero EN pulses, FSM back in IDLE.
REQ-036 btn_dn held 4 ticks, then released -> exactly one EN with cnt=1, and EN high for exactly one clk.
REQ-037 btn_up held 12 ticks, then btn_dn also pressed -> LOCKOUT, no further EN until both buttons are low for 3 ticks.
REQ-038 rst pulsed low while in REPEAT with btn_up still high -> outputs 0 immediately; after rst release, the next EN occurs only after a full debounce and only if btn_up is still high.
